// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: syndrome type, parity-check masks and bit positions.
// Bit i of a 7-bit word is Hamming position i+1.
package hamming_pkg;

    typedef logic [2:0] sindrome_t;

    localparam logic [6:0] MASK_S1 = 7'b101_0101;
    localparam logic [6:0] MASK_S2 = 7'b110_0110;
    localparam logic [6:0] MASK_S4 = 7'b111_1000;

    localparam int unsigned PARITY_POS [3] = '{1, 2, 4};
    localparam int unsigned DATA_POS   [4] = '{3, 5, 6, 7};

    // A nonzero syndrome names the faulty position directly.
    function automatic logic [6:0] flip_mask(input sindrome_t s);
        logic [6:0] m;
        m = '0;
        if (s != 3'd0) begin
            m[s - 3'd1] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/module_sindrome.sv
// Combinational syndrome {s4,s2,s1} of a received Hamming(7,4) word.
module module_sindrome
    import hamming_pkg::*;
(
    input  logic [6:0] datos_i,
    output sindrome_t  sindrome_o
);

    assign sindrome_o = {^(datos_i & MASK_S4), ^(datos_i & MASK_S2), ^(datos_i & MASK_S1)};

endmodule

// File: rtl/module_corrector.sv
// Single-error Hamming(7,4) corrector behind a one-entry valid/ready register,
// with a saturating count of accepted words that carried an error.
module module_corrector
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       datos_rx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       datos_cod,
    output logic [2:0]       sindrome,
    output logic             error,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshake: a word moves on an edge where valid and ready are both high;
    // the producer keeps valid/data steady until that edge, and ready never
    // depends on the producer's valid.
    sindrome_t        syn_rx;
    logic             accept;
    logic             valid_q, valid_d;
    logic [6:0]       cod_q, cod_d;
    sindrome_t        syn_q, syn_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    module_sindrome u_sindrome (
        .datos_i    (datos_rx),
        .sindrome_o (syn_rx)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        cod_d   = cod_q;
        syn_d   = syn_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (accept) begin
            valid_d = 1'b1;
            cod_d   = datos_rx ^ flip_mask(syn_rx);
            syn_d   = syn_rx;
            err_d   = (syn_rx != 3'd0);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        // Clear wins over a same-cycle increment.
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (accept && (syn_rx != 3'd0) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            cod_q   <= '0;
            syn_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cod_q   <= cod_d;
            syn_q   <= syn_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign datos_cod = cod_q;
    assign sindrome  = syn_q;
    assign error     = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_module_corrector.sv
// Directed bench for module_corrector: a default-width instance and a 2-bit
// counter instance share the same stimulus.
module tb_module_corrector;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       clr_cnt;
    logic [6:0] datos_rx;

    logic       d8_in_ready, d8_out_valid, d8_error;
    logic [6:0] d8_cod;
    logic [2:0] d8_syn;
    logic [7:0] d8_cnt;

    logic       d2_in_ready, d2_out_valid, d2_error;
    logic [6:0] d2_cod;
    logic [2:0] d2_syn;
    logic [1:0] d2_cnt;

    int tests;
    int fails;
    int exp8;

    module_corrector #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d8_in_ready),
        .datos_rx(datos_rx), .out_valid(d8_out_valid), .out_ready(out_ready),
        .datos_cod(d8_cod), .sindrome(d8_syn), .error(d8_error),
        .clr_cnt(clr_cnt), .err_cnt(d8_cnt)
    );

    module_corrector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready),
        .datos_rx(datos_rx), .out_valid(d2_out_valid), .out_ready(out_ready),
        .datos_cod(d2_cod), .sindrome(d2_syn), .error(d2_error),
        .clr_cnt(clr_cnt), .err_cnt(d2_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        tests++; if (d8_out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", d8_out_valid); end
        tests++; if (d8_cod !== 7'd0) begin fails++; $display("FAIL rst_cod: got %b want 0000000", d8_cod); end
        tests++; if (d8_syn !== 3'd0) begin fails++; $display("FAIL rst_syn: got %b want 000", d8_syn); end
        tests++; if (d8_error !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", d8_error); end
        tests++; if (d8_cnt !== 8'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", d8_cnt); end
        tests++; if (d8_in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", d8_in_ready); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_pass();
        datos_rx = 7'b000_0111; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests++; if (d8_out_valid !== 1'b1) begin fails++; $display("FAIL pass_valid: got %b want 1", d8_out_valid); end
        tests++; if (d8_cod !== 7'b000_0111) begin fails++; $display("FAIL pass_cod: got %b want 0000111", d8_cod); end
        tests++; if (d8_syn !== 3'b000) begin fails++; $display("FAIL pass_syn: got %b want 000", d8_syn); end
        tests++; if (d8_error !== 1'b0) begin fails++; $display("FAIL pass_err: got %b want 0", d8_error); end
        tests++; if (d8_cnt !== 8'd0) begin fails++; $display("FAIL pass_cnt: got %0d want 0", d8_cnt); end
    endtask

    task automatic test_single_error();
        logic [6:0] base;
        logic [6:0] c;
        logic [3:0] data;
        base = 7'b001_1001;
        // Position 1 flipped.
        datos_rx = 7'b000_0110; in_valid = 1'b1; out_ready = 1'b1;
        step();
        exp8 = 1;
        tests++; if (d8_cod !== 7'b000_0111) begin fails++; $display("FAIL p1_cod: got %b want 0000111", d8_cod); end
        tests++; if (d8_syn !== 3'b001) begin fails++; $display("FAIL p1_syn: got %b want 001", d8_syn); end
        tests++; if (d8_error !== 1'b1) begin fails++; $display("FAIL p1_err: got %b want 1", d8_error); end
        tests++; if (d8_cnt !== 8'(exp8)) begin fails++; $display("FAIL p1_cnt: got %0d want %0d", d8_cnt, exp8); end
        // Position 7 flipped; data bits sit at positions 3,5,6,7.
        datos_rx = 7'b101_1001;
        step();
        exp8 = 2;
        c = d8_cod;
        data = {c[6], c[5], c[4], c[2]};
        tests++; if (d8_cod !== 7'b001_1001) begin fails++; $display("FAIL p7_cod: got %b want 0011001", d8_cod); end
        tests++; if (d8_syn !== 3'b111) begin fails++; $display("FAIL p7_syn: got %b want 111", d8_syn); end
        tests++; if (data !== 4'b0010) begin fails++; $display("FAIL p7_data: got %b want 0010", data); end
        tests++; if (d8_cnt !== 8'(exp8)) begin fails++; $display("FAIL p7_cnt: got %0d want %0d", d8_cnt, exp8); end
        // Every single-bit error on the same codeword, back to back.
        for (int k = 1; k <= 7; k++) begin
            datos_rx = base ^ (7'd1 << (k - 1));
            step();
            exp8++;
            tests++; if (d8_cod !== base) begin fails++; $display("FAIL flip%0d_cod: got %b want %b", k, d8_cod, base); end
            tests++; if (d8_syn !== 3'(k)) begin fails++; $display("FAIL flip%0d_syn: got %b want %0d", k, d8_syn, k); end
            tests++; if (d8_cnt !== 8'(exp8)) begin fails++; $display("FAIL flip%0d_cnt: got %0d want %0d", k, d8_cnt, exp8); end
        end
        in_valid = 1'b0;
        step();
        tests++; if (d8_out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid: got %b want 0", d8_out_valid); end
    endtask

    task automatic test_back_to_back();
        datos_rx = 7'b000_0111; in_valid = 1'b1; out_ready = 1'b0;
        step();
        datos_rx = 7'b101_1001;
        for (int i = 0; i < 5; i++) begin
            tests++; if (d8_in_ready !== 1'b0) begin fails++; $display("FAIL stall%0d_ready: got %b want 0", i, d8_in_ready); end
            tests++; if (d8_out_valid !== 1'b1) begin fails++; $display("FAIL stall%0d_valid: got %b want 1", i, d8_out_valid); end
            tests++; if (d8_cod !== 7'b000_0111 || d8_syn !== 3'd0 || d8_error !== 1'b0) begin
                fails++; $display("FAIL stall%0d_hold: got %b/%b/%b want 0000111/000/0", i, d8_cod, d8_syn, d8_error);
            end
            step();
        end
        tests++; if (d8_cnt !== 8'(exp8)) begin fails++; $display("FAIL stall_cnt: got %0d want %0d", d8_cnt, exp8); end
        out_ready = 1'b1;
        #1;
        tests++; if (d8_in_ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %b want 1", d8_in_ready); end
        step();
        exp8++;
        tests++; if (d8_out_valid !== 1'b1 || d8_cod !== 7'b001_1001 || d8_syn !== 3'b111) begin
            fails++; $display("FAIL b2b1: got v=%b %b/%b want v=1 0011001/111", d8_out_valid, d8_cod, d8_syn);
        end
        datos_rx = 7'b000_0110;
        step();
        exp8++;
        tests++; if (d8_out_valid !== 1'b1 || d8_cod !== 7'b000_0111 || d8_syn !== 3'b001) begin
            fails++; $display("FAIL b2b2: got v=%b %b/%b want v=1 0000111/001", d8_out_valid, d8_cod, d8_syn);
        end
        in_valid = 1'b0;
        step();
        tests++; if (d8_out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b want 0", d8_out_valid); end
        tests++; if (d8_cnt !== 8'(exp8)) begin fails++; $display("FAIL b2b_cnt: got %0d want %0d", d8_cnt, exp8); end
    endtask

    task automatic test_saturation();
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        exp8 = 0;
        tests++; if (d8_cnt !== 8'd0 || d2_cnt !== 2'd0) begin fails++; $display("FAIL clr_idle: got %0d/%0d want 0/0", d8_cnt, d2_cnt); end
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            datos_rx = 7'b001_1001 ^ (7'd1 << i);
            step();
            exp8++;
            tests++; if (d2_cnt !== sat_exp[i]) begin fails++; $display("FAIL sat%0d_cnt2: got %0d want %0d", i, d2_cnt, sat_exp[i]); end
            tests++; if (d8_cnt !== 8'(exp8)) begin fails++; $display("FAIL sat%0d_cnt8: got %0d want %0d", i, d8_cnt, exp8); end
        end
        datos_rx = 7'b000_0110; clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0; in_valid = 1'b0;
        exp8 = 0;
        tests++; if (d2_cnt !== 2'd0 || d8_cnt !== 8'd0) begin fails++; $display("FAIL clr_acc_cnt: got %0d/%0d want 0/0", d2_cnt, d8_cnt); end
        tests++; if (d2_error !== 1'b1 || d2_cod !== 7'b000_0111) begin fails++; $display("FAIL clr_acc_word: got %b/%b want 1/0000111", d2_error, d2_cod); end
        step();
    endtask

    task automatic test_async_reset();
        datos_rx = 7'b000_0110; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        tests++; if (d8_out_valid !== 1'b1 || d8_cnt !== 8'd1) begin fails++; $display("FAIL arst_pre: got v=%b cnt=%0d want v=1 cnt=1", d8_out_valid, d8_cnt); end
        #3;
        rst_n = 1'b0;
        #1;
        tests++; if (d8_out_valid !== 1'b0 || d2_out_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b/%b want 0/0", d8_out_valid, d2_out_valid); end
        tests++; if (d8_cod !== 7'd0 || d8_syn !== 3'd0 || d8_error !== 1'b0) begin
            fails++; $display("FAIL arst_word: got %b/%b/%b want 0000000/000/0", d8_cod, d8_syn, d8_error);
        end
        tests++; if (d8_cnt !== 8'd0 || d2_cnt !== 2'd0) begin fails++; $display("FAIL arst_cnt: got %0d/%0d want 0/0", d8_cnt, d2_cnt); end
        // Traffic during reset must be ignored.
        datos_rx = 7'b000_0110; in_valid = 1'b1; out_ready = 1'b1;
        step();
        step();
        tests++; if (d8_out_valid !== 1'b0 || d8_cnt !== 8'd0) begin fails++; $display("FAIL arst_ignore: got v=%b cnt=%0d want v=0 cnt=0", d8_out_valid, d8_cnt); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        tests++; if (d8_in_ready !== 1'b1) begin fails++; $display("FAIL arst_ready: got %b want 1", d8_in_ready); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests++; if (d8_out_valid !== 1'b1 || d8_cod !== 7'b000_0111 || d8_syn !== 3'b001) begin
            fails++; $display("FAIL arst_next: got v=%b %b/%b want v=1 0000111/001", d8_out_valid, d8_cod, d8_syn);
        end
        tests++; if (d8_cnt !== 8'd1) begin fails++; $display("FAIL arst_next_cnt: got %0d want 1", d8_cnt); end
        step();
    endtask

    initial begin
        tests = 0; fails = 0; exp8 = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0; datos_rx = '0;
        test_reset();
        test_pass();
        test_single_error();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
